// File: rtl/lfsr_rng_gen_if.sv
// Request/valid bundle between a consumer and the LFSR random-number generator.
// The consumer drives the master side; the generator implements the slave side.
interface lfsr_rng_gen_if #(
    parameter int WIDTH = 15
);
    logic             en;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             req;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] rnd;

    modport master (
        output en,
        output seed_load,
        output seed_in,
        output req,
        input  busy,
        input  valid,
        input  rnd
    );

    modport slave (
        input  en,
        input  seed_load,
        input  seed_in,
        input  req,
        output busy,
        output valid,
        output rnd
    );
endinterface

// File: rtl/lfsr_rng_gen.sv
// Fibonacci LFSR random-number generator with request/valid handshake, runtime seed load
// and all-zero lockup recovery. Define RNG_RANGE_EN to range-limit samples by rejection.
module lfsr_rng_gen #(
    parameter int               WIDTH  = 15,
    parameter logic [WIDTH-1:0] TAPS   = 15'h6000,
    parameter logic [WIDTH-1:0] SEED   = 15'h000F,
    parameter int               SHIFTS = 15,
    parameter int               RANGE  = 120
) (
    input logic           clk,
    input logic           rst,
    lfsr_rng_gen_if.slave bus
);
    localparam int CW = $clog2(SHIFTS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(SHIFTS - 1);

    if (WIDTH < 3 || SHIFTS < 1 || SEED == '0 || RANGE < 2) begin : g_bad_param
        $error("lfsr_rng_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] tapped;
    logic             fb;
    logic [WIDTH-1:0] stepped;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
        assign tapped[gi] = lfsr_q[gi] & TAPS[gi];
    end

    assign fb      = ^tapped;
    assign stepped = {lfsr_q[WIDTH-2:0], fb};

`ifdef RNG_RANGE_EN
    localparam int RW = $clog2(RANGE);
    localparam logic [RW:0] RANGE_L = (RW + 1)'(RANGE);
    logic [RW-1:0] cand;
    logic          cand_ok;
    assign cand    = lfsr_q[RW-1:0];
    assign cand_ok = ({1'b0, cand} < RANGE_L);
`endif

    always_comb begin
        fsm_d   = fsm_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        valid_d = 1'b0;

        case (fsm_q)
            ST_IDLE: begin
                // Free-running steps harvest entropy from the consumer's en timing.
                if (bus.en) begin
                    lfsr_d = stepped;
                end
                if (bus.req) begin
                    fsm_d = ST_SHIFT;
                    cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                lfsr_d = stepped;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef RNG_RANGE_EN
                if (cand_ok) begin
                    rnd_d   = WIDTH'(cand);
                    valid_d = 1'b1;
                    fsm_d   = ST_IDLE;
                end else begin
                    fsm_d = ST_SHIFT;
                    cnt_d = '0;
                end
`else
                rnd_d   = lfsr_q;
                valid_d = 1'b1;
                fsm_d   = ST_IDLE;
`endif
            end
            default: begin
                fsm_d = ST_IDLE;
                cnt_d = '0;
            end
        endcase

        // A zero state would never leave zero; recover from a bad tap mask or seed.
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end

        if (bus.seed_load) begin
            lfsr_d  = (bus.seed_in == '0) ? SEED : bus.seed_in;
            fsm_d   = ST_IDLE;
            cnt_d   = '0;
            rnd_d   = rnd_q;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q   <= ST_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
        end
    end

    assign bus.busy  = (fsm_q != ST_IDLE);
    assign bus.valid = valid_q;
    assign bus.rnd   = rnd_q;
endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Bench for lfsr_rng_gen: the reference model is a position pointer into a precomputed
// maximal-length sequence, advanced by the number of steps the handshake rules imply.
module tb_lfsr_rng_gen;
    localparam int P     = 32767;
    localparam int SEEDV = 15;
    localparam int RMAX  = 120;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_rng_gen_if #(.WIDTH(15)) bus ();

    lfsr_rng_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int seq[P];
    int pos_of[P+1];
    int pos;
    int last_rnd;

    function automatic int seq_next(input int s);
        int fb;
        fb = ((s >> 14) ^ (s >> 13)) & 1;
        return ((s << 1) & 32'h7FFF) | fb;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance the model by one delivered sample; rej counts rejected candidates.
    task automatic predict(output int val, output int rej);
        rej = 0;
        pos = (pos + 15) % P;
        val = seq[pos];
`ifdef RNG_RANGE_EN
        while ((val % 128) >= RMAX) begin
            pos = (pos + 15) % P;
            val = seq[pos];
            rej++;
        end
        val = val % 128;
`endif
    endtask

    task automatic get_sample(input int limit, input bit rnd_en, output int cycles, output bit got);
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < limit) begin
            cyc();
            cycles++;
            if (bus.valid) got = 1'b1;
            else if (rnd_en) bus.en = 1'($urandom_range(0, 1));
        end
        bus.en = 1'b0;
    endtask

    task automatic pulse_req();
        bus.req = 1'b1;
        cyc();
        bus.req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        n_tests++; if (bus.rnd !== 15'h0)  begin n_fail++; $display("FAIL reset_rnd got %h want 0", bus.rnd); end
        n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        n_tests++; if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        rst = 1'b1;
        pos = 0;
        $display("[TB] reset: rnd=%h valid=%b busy=%b", bus.rnd, bus.valid, bus.busy);
    endtask

    task automatic test_single();
        int busy_cnt, valid_cnt, vat, exp, rej;
        predict(exp, rej);
        pulse_req();
        busy_cnt  = bus.busy ? 1 : 0;
        valid_cnt = 0;
        vat       = -1;
        for (int i = 1; i <= 24; i++) begin
            cyc();
            if (bus.busy) busy_cnt++;
            if (bus.valid) begin valid_cnt++; vat = i; end
        end
        n_tests++; if (busy_cnt != 16)  begin n_fail++; $display("FAIL single_busy got %0d want 16", busy_cnt); end
        n_tests++; if (valid_cnt != 1)  begin n_fail++; $display("FAIL single_valid_cnt got %0d want 1", valid_cnt); end
        n_tests++; if (vat != 16)       begin n_fail++; $display("FAIL single_latency got %0d want 16", vat); end
        n_tests++; if (bus.rnd !== 15'h0011) begin n_fail++; $display("FAIL single_rnd got %h want 0011", bus.rnd); end
        n_tests++; if (bus.rnd !== 15'(exp)) begin n_fail++; $display("FAIL single_model got %h want %h", bus.rnd, 15'(exp)); end
        last_rnd = exp;
        $display("[TB] single: rnd=%h busy_cycles=%0d latency=%0d", bus.rnd, busy_cnt, vat);
    endtask

    task automatic test_back_to_back();
        int exp, rej, cycles, want, prev;
        bit got;
        prev    = -1;
        bus.req = 1'b1;
        cyc();
        for (int k = 0; k < 6; k++) begin
            predict(exp, rej);
            want = ((k == 0) ? 16 : 17) + 16 * rej;
            get_sample(2000, 1'b1, cycles, got);
            n_tests++; if (!got) begin n_fail++; $display("FAIL b2b_timeout sample %0d", k); break; end
            n_tests++; if (cycles != want) begin n_fail++; $display("FAIL b2b_interval got %0d want %0d", cycles, want); end
            n_tests++; if (bus.rnd !== 15'(exp)) begin n_fail++; $display("FAIL b2b_value got %h want %h", bus.rnd, 15'(exp)); end
            n_tests++; if (int'(bus.rnd) == prev) begin n_fail++; $display("FAIL b2b_duplicate got %h want not %h", bus.rnd, 15'(prev)); end
            prev     = int'(bus.rnd);
            last_rnd = exp;
            $display("[TB] b2b %0d: rnd=%h interval=%0d", k, bus.rnd, cycles);
        end
        bus.req = 1'b0;
        cyc();
    endtask

    task automatic test_random_en();
        int seed, n, k, exp, rej, cycles;
        bit got;
        for (int it = 0; it < 8; it++) begin
            seed          = $urandom_range(1, P);
            bus.seed_load = 1'b1;
            bus.seed_in   = 15'(seed);
            cyc();
            bus.seed_load = 1'b0;
            pos           = pos_of[seed];
            n             = $urandom_range(0, 60);
            k             = 0;
            for (int i = 0; i < n; i++) begin
                bus.en = 1'($urandom_range(0, 1));
                k += int'(bus.en);
                cyc();
            end
            bus.en = 1'b0;
            pos    = (pos + k) % P;
            predict(exp, rej);
            pulse_req();
            get_sample(2000, 1'b1, cycles, got);
            n_tests++; if (!got) begin n_fail++; $display("FAIL rnd_en_timeout iter %0d", it); break; end
            n_tests++; if (bus.rnd !== 15'(exp)) begin n_fail++; $display("FAIL rnd_en_value got %h want %h", bus.rnd, 15'(exp)); end
            n_tests++; if (cycles != 16 + 16 * rej) begin n_fail++; $display("FAIL rnd_en_latency got %0d want %0d", cycles, 16 + 16 * rej); end
            last_rnd = exp;
            $display("[TB] rnd_en %0d: seed=%h en_steps=%0d rnd=%h", it, 15'(seed), k, bus.rnd);
        end
    endtask

    task automatic test_seed_abort();
        int vcnt, cycles;
        bit got;
        pulse_req();
        repeat (5) cyc();
        bus.seed_load = 1'b1;
        bus.seed_in   = 15'h0;
        cyc();
        bus.seed_load = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        vcnt = 0;
        repeat (30) begin cyc(); if (bus.valid) vcnt++; end
        n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL abort_valid got %0d want 0", vcnt); end
        n_tests++; if (bus.rnd !== 15'(last_rnd)) begin n_fail++; $display("FAIL abort_rnd_held got %h want %h", bus.rnd, 15'(last_rnd)); end
        pos = 0;
        pulse_req();
        get_sample(2000, 1'b0, cycles, got);
        n_tests++; if (!got || bus.rnd !== 15'h0011) begin n_fail++; $display("FAIL abort_resample got %h want 0011", bus.rnd); end
        n_tests++; if (cycles != 16) begin n_fail++; $display("FAIL abort_latency got %0d want 16", cycles); end
        pos = 15;
        last_rnd = 'h11;
        $display("[TB] seed_abort: valids_after_abort=%0d resample=%h", vcnt, bus.rnd);
    endtask

    task automatic test_seed_req_same();
        int seed, vcnt, bcnt, exp, rej, cycles;
        bit got;
        seed          = $urandom_range(1, P);
        bus.seed_load = 1'b1;
        bus.seed_in   = 15'(seed);
        bus.req       = 1'b1;
        cyc();
        bus.seed_load = 1'b0;
        bus.req       = 1'b0;
        vcnt = 0;
        bcnt = bus.busy ? 1 : 0;
        repeat (25) begin cyc(); if (bus.valid) vcnt++; if (bus.busy) bcnt++; end
        n_tests++; if (bcnt != 0) begin n_fail++; $display("FAIL same_busy got %0d want 0", bcnt); end
        n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL same_valid got %0d want 0", vcnt); end
        pos = pos_of[seed];
        predict(exp, rej);
        pulse_req();
        get_sample(2000, 1'b0, cycles, got);
        n_tests++; if (!got || bus.rnd !== 15'(exp)) begin n_fail++; $display("FAIL same_sample got %h want %h", bus.rnd, 15'(exp)); end
        last_rnd = exp;
        $display("[TB] seed_req_same: seed=%h busy_cycles=%0d rnd=%h", 15'(seed), bcnt, bus.rnd);
    endtask

    task automatic test_reset_mid();
        int vcnt, cycles, exp, rej;
        bit got;
        pulse_req();
        repeat (6) cyc();
        rst = 1'b0;
        cyc();
        n_tests++; if (bus.rnd !== 15'h0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs got rnd=%h v=%b b=%b want 0/0/0", bus.rnd, bus.valid, bus.busy);
        end
        rst  = 1'b1;
        vcnt = 0;
        repeat (25) begin cyc(); if (bus.valid) vcnt++; end
        n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL midrst_valid got %0d want 0", vcnt); end
        bus.en = 1'b1;
        repeat (P) cyc();
        bus.en = 1'b0;
        pos = 0;
        predict(exp, rej);
        pulse_req();
        get_sample(2000, 1'b0, cycles, got);
        n_tests++; if (!got || bus.rnd !== 15'h0011) begin n_fail++; $display("FAIL period got %h want 0011", bus.rnd); end
        n_tests++; if (bus.rnd !== 15'(exp)) begin n_fail++; $display("FAIL period_model got %h want %h", bus.rnd, 15'(exp)); end
        last_rnd = exp;
        $display("[TB] reset_mid+period: rnd=%h", bus.rnd);
    endtask

`ifdef RNG_RANGE_EN
    task automatic test_range();
        int exp, rej, cycles, rej_seen, bad;
        bit got;
        rej_seen = 0;
        bad      = 0;
        bus.req  = 1'b1;
        cyc();
        for (int k = 0; k < 2000; k++) begin
            predict(exp, rej);
            get_sample(2000, 1'b0, cycles, got);
            n_tests++; if (!got) begin n_fail++; $display("FAIL range_timeout sample %0d", k); break; end
            n_tests++; if (int'(bus.rnd) >= RMAX || bus.rnd !== 15'(exp)) begin
                n_fail++; bad++; $display("FAIL range_sample %0d got %h want %h (<%0d)", k, bus.rnd, 15'(exp), RMAX);
            end
            if (cycles > 17) rej_seen++;
        end
        bus.req = 1'b0;
        cyc();
        n_tests++; if (rej_seen == 0) begin n_fail++; $display("FAIL range_rejection got %0d want >0", rej_seen); end
        $display("[TB] range: 2000 samples, bad=%0d, long_latency=%0d", bad, rej_seen);
    endtask
`endif

    initial begin
        int s;
        bus.en        = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = 15'h0;
        bus.req       = 1'b0;
        last_rnd      = 0;
        s = SEEDV;
        for (int i = 0; i < P; i++) begin
            seq[i]    = s;
            pos_of[s] = i;
            s         = seq_next(s);
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_random_en();
        test_seed_abort();
        test_seed_req_same();
        test_reset_mid();
`ifdef RNG_RANGE_EN
        test_range();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
